// File: rtl/shift_pkg.sv
// Shared constants for the shift_reg block.
//
// DIR_LEFT  : shift toward the MSB, zero fill at the LSB.
// DIR_RIGHT : shift toward the LSB, zero fill at the MSB.
package shift_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage : shift_pkg

// File: rtl/shift_cell.sv
// Next-state selector for one bit of the shift register.
// This cell is purely combinational. The flop that holds the bit is in shift_reg.
//
// Ports:
//   load  - 1 = take the parallel-load bit d; 0 = take a neighbour bit
//   dir   - shift direction (DIR_LEFT / DIR_RIGHT), ignored while load=1
//   d     - parallel-load bit for this position
//   lower - current value of the next less-significant bit (0 at bit 0)
//   upper - current value of the next more-significant bit (0 at bit N-1)
//   nxt   - value this bit takes on the next rising clock edge
module shift_cell
    import shift_pkg::*;
(
    input  logic load,
    input  logic dir,
    input  logic d,
    input  logic lower,
    input  logic upper,
    output logic nxt
);

    always_comb begin
        nxt = d;
        if (!load) begin
            // A left shift moves data toward the MSB, so this bit takes its lower neighbour.
            if (dir == DIR_LEFT) begin
                nxt = lower;
            end else begin
                nxt = upper;
            end
        end
    end

endmodule : shift_cell

// File: rtl/shift_reg.sv
// N-bit parallel-load shift register with logical left and right shifts.
//
// Ports:
//   clk - clock; all updates happen on its rising edge
//   rst - asynchronous active-high reset; clears the register immediately
//   dir - 0 = shift left (toward MSB), 1 = shift right (toward LSB)
//   inp - 1 = load a in parallel (dir ignored), 0 = shift by one
//   a   - parallel load data
//   y   - register contents, driven straight from the flops
//
// Parameter N is the register width and must be at least 2.
// The block has no other state, no handshake and no status outputs.
module shift_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dir,
    input  logic         inp,
    input  logic [N-1:0] a,
    output logic [N-1:0] y
);

    logic [N-1:0] r;
    logic [N-1:0] nxt;
    logic [N+1:0] pad;

    // The zero at each end of pad is the missing neighbour of an edge cell.
    // This makes the vacated bit fill with 0 in both directions.
    // Bit i of r is pad[i+1], so pad[i] is its lower neighbour and pad[i+2] is its upper neighbour.
    assign pad = {1'b0, r, 1'b0};

    for (genvar i = 0; i < N; i++) begin : g_cell
        shift_cell u_cell (
            .load  (inp),
            .dir   (dir),
            .d     (a[i]),
            .lower (pad[i]),
            .upper (pad[i+2]),
            .nxt   (nxt[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
        end else begin
            r <= nxt;
        end
    end

    assign y = r;

endmodule : shift_reg

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg (N = 8).
module tb_shift_reg;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         dir;
    logic         inp;
    logic [N-1:0] a;
    logic [N-1:0] y;

    int checks;
    int errors;

    typedef struct {
        logic         inp;
        logic         dir;
        logic [N-1:0] a;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    shift_reg #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .dir (dir),
        .inp (inp),
        .a   (a),
        .y   (y)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // comparison
    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: y=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one set of inputs after a falling edge, then wait until just past the next rising edge.
    task automatic apply(input logic i_inp, input logic i_dir, input logic [N-1:0] i_a);
        @(negedge clk);
        inp = i_inp;
        dir = i_dir;
        a   = i_a;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the register value as an integer in the range 0 .. 2**N-1.
    function automatic int unsigned model_next(input int unsigned cur, input logic m_inp,
                                               input logic m_dir, input logic [N-1:0] m_a);
        int unsigned modulus;
        modulus = 1 << N;
        if (m_inp) return int'(m_a);
        if (m_dir == 1'b0) return (cur * 2) % modulus;
        return cur / 2;
    endfunction

    int unsigned m;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        inp = 1'b0;
        dir = 1'b0;
        a   = '0;

        // reset state, before any clock edge and while reset is held
        #2;
        check("reset_initial", y, 8'h00);
        @(posedge clk);
        #1;
        check("reset_held", y, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // directed vector table
        // During shift cycles a is driven to a non-zero value so that a leaking load would be detected.
        vecs.push_back('{1'b1, 1'b0, 8'hAA, 8'hAA});   // load / left shift
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h54});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'hA8});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'h50});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 8'hA0});
        vecs.push_back('{1'b1, 1'b1, 8'hCD, 8'hCD});   // load / right shift
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h66});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h33});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h19});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h0C});
        vecs.push_back('{1'b1, 1'b0, 8'h18, 8'h18});   // direction change, then a load that wins over the shift
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h30});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h18});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h0C});
        vecs.push_back('{1'b1, 1'b1, 8'h81, 8'h81});
        vecs.push_back('{1'b1, 1'b0, 8'h3C, 8'h3C});   // held load tracks a changing value
        vecs.push_back('{1'b1, 1'b1, 8'hC3, 8'hC3});
        vecs.push_back('{1'b1, 1'b0, 8'h01, 8'h01});
        vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00});   // LSB falls off the right end
        vecs.push_back('{1'b1, 1'b0, 8'h80, 8'h80});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 8'h00});   // MSB falls off the left end

        foreach (vecs[k]) begin
            apply(vecs[k].inp, vecs[k].dir, vecs[k].a);
            check($sformatf("vec%0d", k), y, vecs[k].exp);
        end

        // Drain in both directions: a full register empties after N shifts and stays empty.
        for (int d = 0; d < 2; d++) begin
            apply(1'b1, 1'b0, 8'hFF);
            check("drain_load", y, 8'hFF);
            for (int s = 0; s < N; s++) begin
                apply(1'b0, d[0], 8'hFF);
            end
            check($sformatf("drain_dir%0d_n", d), y, 8'h00);
            apply(1'b0, d[0], 8'hFF);
            check($sformatf("drain_dir%0d_n_plus_1", d), y, 8'h00);
        end

        // Asynchronous reset between edges, then normal operation on the first edge after release.
        apply(1'b1, 1'b0, 8'hAA);
        check("async_pre", y, 8'hAA);
        @(negedge clk);
        inp = 1'b1;
        a   = 8'h0F;
        rst = 1'b1;
        #1;
        check("async_immediate", y, 8'h00);
        @(posedge clk);
        #1;
        check("async_priority", y, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("async_release", y, 8'h0F);

        // Randomized run against the model, with occasional reset pulses between edges.
        m = 32'h0F;
        for (int c = 0; c < 400; c++) begin
            logic r_inp, r_dir;
            logic [N-1:0] r_a;
            r_inp = ($urandom_range(0, 3) == 0);
            r_dir = 1'($urandom_range(0, 1));
            r_a   = N'($urandom_range(0, (1 << N) - 1));
            @(negedge clk);
            inp = r_inp;
            dir = r_dir;
            a   = r_a;
            if ($urandom_range(0, 24) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check("rand_async", y, 8'h00);
                rst = 1'b0;
                m = 0;
            end
            @(posedge clk);
            #1;
            m = model_next(m, r_inp, r_dir, r_a);
            check($sformatf("rand%0d", c), y, N'(m));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shift_reg

// File: doc/shift_reg.md
SHIFT_REG -- requirements
Module: shift_reg

Interface
REQ-001 Parameter N, default 8: register width in bits; legal range N >= 2.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 dir  input  1  shift direction: 0 = left (toward MSB), 1 = right (toward LSB).
REQ-005 inp  input  1  load enable: 1 = parallel load of a, 0 = shift.
REQ-006 a    input  N  parallel load data.
REQ-007 y    output N  current register contents, driven directly from the state register.

Function
REQ-008 The block SHALL hold one N-bit state register R; y SHALL equal R at all times, with no combinational path from any input to y.
REQ-009 On a rising clk edge with rst=0 and inp=1, R SHALL become a; dir is ignored during a load.
REQ-010 On a rising clk edge with rst=0, inp=0 and dir=0, R SHALL become {R[N-2:0], 1'b0}: logical left shift by one, zero fill at the LSB, old MSB discarded.
REQ-011 On a rising clk edge with rst=0, inp=0 and dir=1, R SHALL become {1'b0, R[N-1:1]}: logical right shift by one, zero fill at the MSB, old LSB discarded.
REQ-012 Latency: a load or shift SHALL be visible on y immediately after the edge that samples it (one-cycle register latency, no pipeline).
REQ-013 Shifting SHALL repeat every cycle while inp=0; after N consecutive shift cycles R SHALL be all zeros, and it SHALL stay zero under further shifts.
REQ-014 dir may change on any cycle; each shift SHALL use the dir value sampled at that edge.
REQ-015 inp=1 held for several cycles SHALL reload a on every such edge; a changing during that time SHALL be tracked cycle by cycle.
REQ-016 The block SHALL have no handshake, no status outputs and no state other than R.

Reset
REQ-017 rst=1 SHALL clear R to all zeros immediately, without waiting for a clock edge; y SHALL read 0 while rst=1.
REQ-018 rst has priority over load and shift; asserting rst mid-sequence SHALL abort it, and the first edge after deassertion SHALL act normally on inp, dir and a.

Structure
REQ-019 A shared package shift_pkg SHALL hold the direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
REQ-020 The per-bit next-state selection (load, left neighbour, right neighbour) SHALL live in a sub-module shift_cell, instantiated N times by a generate loop; the edge cells SHALL receive a constant 0 as the missing neighbour.

Verification
REQ-021 Load/left: N=8; load a=10101010 with inp=1, then set inp=0, dir=0 -> y reads 10101010, then 01010100, 10101000, 01010000, 10100000 on successive edges.
REQ-022 Load/right: load a=11001101 with inp=1, then set inp=0, dir=1 -> y reads 11001101, then 01100110, 00110011, 00011001, 00001100.
REQ-023 Drain: load 11111111, shift left 8 cycles -> y=00000000; a 9th shift leaves y=00000000; repeat with dir=1 for the same result.
REQ-024 Async reset: load 10101010, assert rst between clock edges -> y=00000000 before the next edge; deassert rst with inp=1, a=00001111 -> y=00001111 after the next edge.
REQ-025 Direction change and load priority: load 00011000, shift left once -> 00110000; shift right twice -> 00001100; set inp=1 with dir=1, a=10000001 -> y=10000001 (no shift).
